reg_file_mp: RTL and testbench

- Parametrised multi-port register file for the Xenyx-4 cores, next generation of the single-write-port register file.
- Provides 2 read ports, 2 write ports (ALU writeback, load/MUL writeback), a per-register busy scoreboard for hazard stalls, and a multi-cycle context-clear sequencer used on core reassignment.
- Sits between decode (reads, issue) and writeback (writes) in each core.

---
 rtl/reg_file_mp.sv | 153 +++++++++++++++
 tb/tb_reg_file_mp.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file for the Xenyx-4 cores.
// It has two combinational read ports with write forwarding, two write ports
// (port 1 wins when both write the same address), a per-register busy
// scoreboard, and a sequencer that zeroes the whole file one register per
// cycle when the core is reassigned.
module reg_file_mp #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter bit ZERO_REG_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              rbusy1,
  output logic              rbusy2,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic              iss_v,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int NREGS = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_mem [NREGS];
  logic [NREGS-1:0]  r_busy;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_clr_busy;
  logic              r_clr_done;

  logic w_idle;
  logic w_upd;
  logic w_fw0;
  logic w_fw1;
  logic w_st0;
  logic w_st1;

  assign w_idle = (r_state == S_IDLE);
  // A clear request seen in IDLE takes priority over writes and issues on that edge.
  assign w_upd  = w_idle && !clr_req;
  assign w_fw0  = w_idle && we0;
  assign w_fw1  = w_idle && we1;
  assign w_st0  = w_upd && we0 && !(ZERO_REG_EN && (wa0 == '0));
  assign w_st1  = w_upd && we1 && !(ZERO_REG_EN && (wa1 == '0));

  function automatic logic [DATA_W-1:0] f_read(input logic [ADDR_W-1:0] a);
    if (ZERO_REG_EN && (a == '0))  return '0;
    else if (w_fw1 && (wa1 == a))  return wd1;
    else if (w_fw0 && (wa0 == a))  return wd0;
    else                           return r_mem[a];
  endfunction

  // A write landing this cycle resolves the hazard, unless a new producer is
  // issued to the same register on the same edge.
  function automatic logic f_busy(input logic [ADDR_W-1:0] a);
    if (r_state == S_CLEAR)                return 1'b1;
    else if (w_idle && iss_v && (iss_rd == a)) return r_busy[a];
    else return r_busy[a] & ~((w_fw0 && (wa0 == a)) || (w_fw1 && (wa1 == a)));
  endfunction

  // Read ports: zero register, forwarding, then array contents.
  always_comb begin
    rd1    = f_read(ra1);
    rd2    = f_read(ra2);
    rbusy1 = f_busy(ra1);
    rbusy2 = f_busy(ra2);
  end

  assign clr_busy = r_clr_busy;
  assign clr_done = r_clr_done;

  // Clear sequencer: IDLE -> CLEAR (one register per cycle) -> DONE -> IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_clr_busy <= 1'b0;
      r_clr_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_clr_done <= 1'b0;
          if (clr_req) begin
            r_state    <= S_CLEAR;
            r_cnt      <= '0;
            r_clr_busy <= 1'b1;
          end
        end
        S_CLEAR: begin
          // Terminal count is the last index, so the counter never wraps.
          if (r_cnt == '1) begin
            r_state    <= S_DONE;
            r_clr_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          r_clr_busy <= 1'b0;
          r_clr_done <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_clr_busy <= 1'b0;
          r_clr_done <= 1'b0;
        end
      endcase
    end
  end

  // Register array and busy scoreboard updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
      r_busy <= '0;
    end else if (r_state == S_CLEAR) begin
      r_mem[r_cnt]  <= '0;
      r_busy[r_cnt] <= 1'b0;
    end else if (w_upd) begin
      // Port 1 is assigned last so it wins a same-address conflict.
      if (w_st0) r_mem[wa0] <= wd0;
      if (w_st1) r_mem[wa1] <= wd1;
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (iss_v && (iss_rd == ADDR_W'(i))) begin
          r_busy[i] <= 1'b1;
        end else if ((we0 && (wa0 == ADDR_W'(i))) || (we1 && (wa1 == ADDR_W'(i)))) begin
          r_busy[i] <= 1'b0;
        end
      end
      if (ZERO_REG_EN) r_busy[0] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: default 32x32 instance plus an 8x16
// instance with a writable register 0.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ra1, ra2, wa0, wa1, iss_rd;
  logic [31:0] rd1, rd2, wd0, wd1;
  logic        rbusy1, rbusy2, we0, we1, iss_v, clr_req, clr_busy, clr_done;

  logic [2:0]  b_ra1, b_ra2, b_wa0, b_wa1, b_iss_rd;
  logic [15:0] b_rd1, b_rd2, b_wd0, b_wd1;
  logic        b_rbusy1, b_rbusy2, b_we0, b_we1, b_iss_v, b_clr_req, b_clr_busy, b_clr_done;

  int n_cmp = 0;
  int n_err = 0;
  int s;
  int ndone;

  always #5 clk = ~clk;

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .rbusy1(rbusy1), .rbusy2(rbusy2), .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1), .iss_v(iss_v), .iss_rd(iss_rd),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  reg_file_mp #(.DATA_W(16), .ADDR_W(3), .ZERO_REG_EN(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .ra1(b_ra1), .ra2(b_ra2), .rd1(b_rd1), .rd2(b_rd2),
    .rbusy1(b_rbusy1), .rbusy2(b_rbusy2), .we0(b_we0), .wa0(b_wa0), .wd0(b_wd0),
    .we1(b_we1), .wa1(b_wa1), .wd1(b_wd1), .iss_v(b_iss_v), .iss_rd(b_iss_rd),
    .clr_req(b_clr_req), .clr_busy(b_clr_busy), .clr_done(b_clr_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; ra1 = '0; ra2 = '0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
    we0 = 1'b0; we1 = 1'b0; iss_v = 1'b0; iss_rd = '0; clr_req = 1'b0;
    b_ra1 = '0; b_ra2 = '0; b_wa0 = '0; b_wa1 = '0; b_wd0 = '0; b_wd1 = '0;
    b_we0 = 1'b0; b_we1 = 1'b0; b_iss_v = 1'b0; b_iss_rd = '0; b_clr_req = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk);
    ra1 = 5'd9; #1;
    chk("rst_rd1", rd1, 32'h0);
    chk("rst_rbusy1", {31'b0, rbusy1}, 32'h0);
    chk("rst_clr_busy", {31'b0, clr_busy}, 32'h0);
    chk("rst_clr_done", {31'b0, clr_done}, 32'h0);
    rst = 1'b0;

    // Forwarded write, then array read
    @(negedge clk); we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; ra1 = 5'd5; #1;
    chk("fwd_r5", rd1, 32'hDEADBEEF);
    @(negedge clk); we0 = 1'b0; #1;
    chk("arr_r5", rd1, 32'hDEADBEEF);

    // Same-address write conflict: port 1 wins
    @(negedge clk); we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11111111;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22222222; ra2 = 5'd7; #1;
    chk("conf_fwd_r7", rd2, 32'h22222222);
    @(negedge clk); we0 = 1'b0; we1 = 1'b0; #1;
    chk("conf_arr_r7", rd2, 32'h22222222);

    // Register 0 is hardwired
    @(negedge clk); we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF; ra1 = 5'd0; #1;
    chk("r0_fwd", rd1, 32'h0);
    chk("r0_busy", {31'b0, rbusy1}, 32'h0);
    @(negedge clk); we0 = 1'b0; #1;
    chk("r0_arr", rd1, 32'h0);

    // Scoreboard set by issue, released by write with forwarding
    @(negedge clk); iss_v = 1'b1; iss_rd = 5'd3; ra1 = 5'd3; #1;
    chk("iss_same_cyc", {31'b0, rbusy1}, 32'h0);
    @(negedge clk); iss_v = 1'b0; #1;
    chk("busy_set", {31'b0, rbusy1}, 32'h1);
    @(negedge clk); we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h0000ABCD; #1;
    chk("busy_fwd_rel", {31'b0, rbusy1}, 32'h0);
    chk("busy_fwd_data", rd1, 32'h0000ABCD);
    @(negedge clk); we1 = 1'b0; #1;
    chk("busy_cleared", {31'b0, rbusy1}, 32'h0);
    chk("r3_arr", rd1, 32'h0000ABCD);

    // Same-cycle issue and write: set wins
    @(negedge clk); iss_v = 1'b1; iss_rd = 5'd3; we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h5; #1;
    chk("iss_wr_not_busy", {31'b0, rbusy1}, 32'h0);
    @(negedge clk); iss_v = 1'b0; we0 = 1'b0; #1;
    chk("iss_wr_set_wins", {31'b0, rbusy1}, 32'h1);
    chk("iss_wr_data", rd1, 32'h5);
    @(negedge clk); iss_v = 1'b1; iss_rd = 5'd3; we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h6; #1;
    chk("iss_wr_busy_exc", {31'b0, rbusy1}, 32'h1);
    @(negedge clk); iss_v = 1'b0; we1 = 1'b0; #1;
    chk("iss_wr_still_busy", {31'b0, rbusy1}, 32'h1);

    // Fill r1..r31
    for (int i = 1; i < 32; i++) begin
      @(negedge clk); we0 = 1'b1; wa0 = 5'(i); wd0 = 32'(i) * 32'h01010101;
    end
    @(negedge clk); we0 = 1'b0; ra1 = 5'd31; ra2 = 5'd20; #1;
    chk("fill_r31", rd1, 32'h1F1F1F1F);
    chk("fill_r20", rd2, 32'h14141414);

    // Full clear; writes/issues during the clear are ignored
    @(negedge clk); clr_req = 1'b1;
    @(negedge clk); clr_req = 1'b0;
    ra1 = 5'd2; ra2 = 5'd20;
    we0 = 1'b1; wa0 = 5'd2; wd0 = 32'hBAD0BAD0;
    we1 = 1'b1; wa1 = 5'd20; wd1 = 32'h77;
    iss_v = 1'b1; iss_rd = 5'd4;
    s = 0; ndone = 0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (!clr_busy) break;
      s++;
      if (clr_done) ndone++;
      if (s == 1) chk("clear_rbusy", {31'b0, rbusy1}, 32'h1);
      if (s == 5) begin
        chk("clear_partial_r2", rd1, 32'h0);
        chk("clear_raw_r20", rd2, 32'h14141414);
      end
      @(negedge clk);
    end
    we0 = 1'b0; we1 = 1'b0; iss_v = 1'b0;
    chk("clear_busy_cycles", 32'(s), 32'd33);
    chk("clear_done_pulses", 32'(ndone), 32'd1);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); ra1 = 5'(i); #1;
      chk($sformatf("post_clear_r%0d", i), {rbusy1, rd1[30:0]}, {1'b0, 31'h0});
      chk($sformatf("post_clear_hi_r%0d", i), {31'b0, rd1[31]}, 32'h0);
    end

    // Reset in the middle of a clear
    @(negedge clk); we0 = 1'b1; wa0 = 5'd20; wd0 = 32'h55;
    @(negedge clk); we0 = 1'b0; ra2 = 5'd20; #1;
    chk("r20_before", rd2, 32'h55);
    @(negedge clk); clr_req = 1'b1;
    @(negedge clk); clr_req = 1'b0;
    s = 0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (!clr_busy) break;
      s++;
      if (s == 11) break;
      @(negedge clk);
    end
    chk("midclr_reached", 32'(s), 32'd11);
    rst = 1'b1; #1;
    chk("midclr_busy", {31'b0, clr_busy}, 32'h0);
    chk("midclr_r20", rd2, 32'h0);
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (clr_done) ndone++;
    end
    chk("midclr_no_done", 32'(ndone), 32'd0);
    @(negedge clk); we0 = 1'b1; wa0 = 5'd6; wd0 = 32'h66; ra1 = 5'd6;
    @(negedge clk); we0 = 1'b0; #1;
    chk("midclr_idle_write", rd1, 32'h66);

    // Small instance: register 0 writable, 8-cycle clear
    @(negedge clk); b_we0 = 1'b1; b_wa0 = 3'd0; b_wd0 = 16'h1234; b_ra1 = 3'd0; #1;
    chk("b_r0_fwd", {16'h0, b_rd1}, 32'h1234);
    @(negedge clk); b_we0 = 1'b0; b_iss_v = 1'b1; b_iss_rd = 3'd0; #1;
    chk("b_r0_arr", {16'h0, b_rd1}, 32'h1234);
    @(negedge clk); b_iss_v = 1'b0; #1;
    chk("b_r0_busy", {31'b0, b_rbusy1}, 32'h1);
    @(negedge clk); b_clr_req = 1'b1;
    @(negedge clk); b_clr_req = 1'b0;
    s = 0; ndone = 0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (!b_clr_busy) break;
      s++;
      if (b_clr_done) ndone++;
      @(negedge clk);
    end
    chk("b_clear_cycles", 32'(s), 32'd9);
    chk("b_clear_done", 32'(ndone), 32'd1);
    @(negedge clk); #1;
    chk("b_r0_cleared", {16'h0, b_rd1}, 32'h0);
    chk("b_r0_unbusy", {31'b0, b_rbusy1}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
